// File: rtl/sprite_pkg.sv
// sprite_pkg: sprite FSM encoding, facing codes and play-field constants
// shared by the sprite and obstacle controllers.
package sprite_pkg;
    typedef enum logic [1:0] {
        ST_ALIVE = 2'd0,
        ST_HIT   = 2'd1,
        ST_DEAD  = 2'd2
    } sprite_state_t;
    localparam logic        DIR_RIGHT     = 1'b0;
    localparam logic        DIR_LEFT      = 1'b1;
    localparam logic [11:0] DEF_KEY_COLOR = 12'h6DE;
    localparam int          FIELD_MAX_X   = 640;
    localparam int          FIELD_MAX_Y   = 480;
    localparam int          FIELD_MIN_Y   = 16;
endpackage

// File: rtl/sprite_pixel_pipe.sv
// sprite_pixel_pipe: inside test, mirrored ROM addressing and one-cycle
// alignment of pixel qualifiers with the synchronous sprite ROM output.
module sprite_pixel_pipe
    import sprite_pkg::*;
#(
    parameter int          SPR_W     = 16,
    parameter int          SPR_H     = 32,
    parameter logic [11:0] KEY_COLOR = DEF_KEY_COLOR,
    parameter int          AW        = $clog2(SPR_W * SPR_H)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [9:0]    x,
    input  logic [9:0]    y,
    input  logic [9:0]    s_x,
    input  logic [9:0]    s_y,
    input  logic          dir,
    input  logic          video_on,
    input  logic          visible,
    input  logic [11:0]   rom_data,
    output logic [AW-1:0] rom_addr,
    output logic [11:0]   rgb_out,
    output logic          sprite_on
);
    logic [9:0] w_col, w_row, w_colm;
    logic       w_inside;
    logic       r_inside, r_video, r_visible;

    always_comb begin
        w_col    = x - s_x;
        w_row    = y - s_y;
        w_inside = (x >= s_x) && (y >= s_y) && ({1'b0, w_col} < 11'(SPR_W)) && ({1'b0, w_row} < 11'(SPR_H));
        w_colm   = (dir == DIR_LEFT) ? 10'(SPR_W - 1) - w_col : w_col;
        rom_addr = w_inside ? AW'(32'(w_row) * 32'(SPR_W) + 32'(w_colm)) : '0;
        // qualifiers were registered with the address, so they line up with rom_data
        sprite_on = r_inside & r_video & r_visible & (rom_data != KEY_COLOR);
        rgb_out   = sprite_on ? rom_data : 12'h000;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_inside  <= 1'b0;
            r_video   <= 1'b0;
            r_visible <= 1'b0;
        end else begin
            r_inside  <= w_inside;
            r_video   <= video_on;
            r_visible <= visible;
        end
    end
endmodule

// File: rtl/sprite_controller.sv
// sprite_controller: player sprite position, facing, lives and invulnerability
// FSM, rendering one pixel per clock through sprite_pixel_pipe.
module sprite_controller
    import sprite_pkg::*;
#(
    parameter int          SPR_W         = 16,
    parameter int          SPR_H         = 32,
    parameter int          SPEED         = 2,
    parameter int          START_X       = 320,
    parameter int          START_Y       = 432,
    parameter int          MIN_X         = 0,
    parameter int          MAX_X         = FIELD_MAX_X,
    parameter int          MIN_Y         = FIELD_MIN_Y,
    parameter int          MAX_Y         = FIELD_MAX_Y,
    parameter int          LIVES         = 3,
    parameter int          INVULN_FRAMES = 120,
    parameter int          BLINK_LOG2    = 3,
    parameter logic [11:0] KEY_COLOR     = DEF_KEY_COLOR,
    parameter int          AW            = $clog2(SPR_W * SPR_H)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          btn_up,
    input  logic          btn_down,
    input  logic          btn_left,
    input  logic          btn_right,
    input  logic          frame_tick,
    input  logic          video_on,
    input  logic [9:0]    x,
    input  logic [9:0]    y,
    input  logic          collision,
    input  logic [11:0]   rom_data,
    output logic [AW-1:0] rom_addr,
    output logic [11:0]   rgb_out,
    output logic          sprite_on,
    output logic [9:0]    s_x,
    output logic [9:0]    s_y,
    output logic          dir,
    output logic [2:0]    lives,
    output logic          invuln,
    output logic          game_over
);
    localparam int IW = $clog2(INVULN_FRAMES + 2);
    localparam logic signed [10:0] X_LO = 11'(MIN_X);
    localparam logic signed [10:0] X_HI = 11'(MAX_X - SPR_W);
    localparam logic signed [10:0] Y_LO = 11'(MIN_Y);
    localparam logic signed [10:0] Y_HI = 11'(MAX_Y - SPR_H);
    localparam logic signed [10:0] SPD  = 11'(SPEED);

    sprite_state_t       r_state, w_next;
    logic [2:0]          r_lives;
    logic [IW-1:0]       r_inv;
    logic [BLINK_LOG2:0] r_frame;
    logic [9:0]          r_sx, r_sy;
    logic                r_dir;
    logic                w_hit, w_move, w_dir, w_visible;
    logic signed [10:0]  w_dx, w_dy, w_nx, w_ny, w_cx, w_cy;

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_ALIVE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = (r_state == ST_ALIVE && collision) ? ((r_lives == 3'd1) ? ST_DEAD : ST_HIT)
               : (r_state == ST_HIT && frame_tick && r_inv <= IW'(1)) ? ST_ALIVE
               : r_state;
    end

    always_comb begin
        invuln    = (r_state == ST_HIT);
        game_over = (r_state == ST_DEAD);
        w_visible = !(r_state == ST_HIT && r_frame[BLINK_LOG2]);
        lives     = r_lives;
        s_x       = r_sx;
        s_y       = r_sy;
        dir       = r_dir;
    end

    // opposing buttons cancel; arithmetic is signed 11-bit so clamping saturates
    always_comb begin
        w_hit  = (r_state == ST_ALIVE) && collision;
        w_move = frame_tick && (r_state != ST_DEAD);
        w_dx   = (btn_right & ~btn_left) ? SPD : (btn_left & ~btn_right) ? -SPD : 11'sd0;
        w_dy   = (btn_down & ~btn_up) ? SPD : (btn_up & ~btn_down) ? -SPD : 11'sd0;
        w_dir  = (btn_right & ~btn_left) ? DIR_RIGHT : (btn_left & ~btn_right) ? DIR_LEFT : r_dir;
        w_nx   = $signed({1'b0, r_sx}) + w_dx;
        w_ny   = $signed({1'b0, r_sy}) + w_dy;
        w_cx   = (w_nx < X_LO) ? X_LO : (w_nx > X_HI) ? X_HI : w_nx;
        w_cy   = (w_ny < Y_LO) ? Y_LO : (w_ny > Y_HI) ? Y_HI : w_ny;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lives <= 3'(LIVES);
            r_inv   <= '0;
            r_frame <= '0;
            r_sx    <= 10'(START_X);
            r_sy    <= 10'(START_Y);
            r_dir   <= DIR_RIGHT;
        end else begin
            if (frame_tick) r_frame <= r_frame + 1'b1;
            if (w_hit) begin
                r_lives <= r_lives - 3'd1;
                r_inv   <= IW'(INVULN_FRAMES);
            end else if (r_state == ST_HIT && frame_tick && r_inv != '0) begin
                r_inv <= r_inv - 1'b1;
            end
            if (w_move) begin
                r_sx  <= 10'(w_cx);
                r_sy  <= 10'(w_cy);
                r_dir <= w_dir;
            end
        end
    end

    sprite_pixel_pipe #(
        .SPR_W    (SPR_W),
        .SPR_H    (SPR_H),
        .KEY_COLOR(KEY_COLOR),
        .AW       (AW)
    ) u_pipe (
        .clk      (clk),
        .reset    (reset),
        .x        (x),
        .y        (y),
        .s_x      (r_sx),
        .s_y      (r_sy),
        .dir      (r_dir),
        .video_on (video_on),
        .visible  (w_visible),
        .rom_data (rom_data),
        .rom_addr (rom_addr),
        .rgb_out  (rgb_out),
        .sprite_on(sprite_on)
    );
endmodule

// File: tb/tb_sprite_controller.sv
// tb_sprite_controller: directed and random stimulus against an integer
// game model of the sprite, with the bench acting as the sprite ROM.
module tb_sprite_controller;
    localparam logic [11:0] KEY = 12'h6DE;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic        frame_tick = 1'b0, video_on = 1'b0, collision = 1'b0;
    logic [9:0]  x = '0, y = '0;
    logic [11:0] rom_data;
    logic [8:0]  rom_addr;
    logic [11:0] rgb_out;
    logic        sprite_on, dir, invuln, game_over;
    logic [9:0]  s_x, s_y;
    logic [2:0]  lives;
    logic [11:0] rom_mem [512];

    int errors = 0, checks = 0;
    int m_x, m_y, m_dir, m_lives, m_mode, m_inv, m_frame;
    bit p_in, p_von, p_vis;
    int p_addr;

    sprite_controller dut (
        .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
        .btn_left(btn_left), .btn_right(btn_right), .frame_tick(frame_tick),
        .video_on(video_on), .x(x), .y(y), .collision(collision),
        .rom_data(rom_data), .rom_addr(rom_addr), .rgb_out(rgb_out),
        .sprite_on(sprite_on), .s_x(s_x), .s_y(s_y), .dir(dir),
        .lives(lives), .invuln(invuln), .game_over(game_over)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int clamp(int v, int lo, int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    function automatic void model_reset();
        m_x = 320; m_y = 432; m_dir = 0; m_lives = 3; m_mode = 0; m_inv = 0; m_frame = 0;
    endfunction

    function automatic bit m_inside(int px, int py);
        return px >= m_x && px < m_x + 16 && py >= m_y && py < m_y + 32;
    endfunction

    function automatic int m_addr(int px, int py);
        int c;
        if (!m_inside(px, py)) return 0;
        c = m_dir ? 15 - (px - m_x) : px - m_x;
        return (py - m_y) * 16 + c;
    endfunction

    function automatic bit m_visible();
        return !(m_mode == 1 && ((m_frame >> 3) & 1) == 1);
    endfunction

    function automatic void model_update();
        int h, v;
        if (reset) begin
            model_reset();
            return;
        end
        h = int'(btn_right) - int'(btn_left);
        v = int'(btn_down) - int'(btn_up);
        if (frame_tick) m_frame++;
        if (frame_tick && m_mode != 2) begin
            if (h != 0) m_dir = (h < 0) ? 1 : 0;
            m_x = clamp(m_x + 2 * h, 0, 624);
            m_y = clamp(m_y + 2 * v, 16, 448);
        end
        if (m_mode == 0 && collision) begin
            m_lives--;
            m_inv  = 120;
            m_mode = (m_lives == 0) ? 2 : 1;
        end else if (m_mode == 1 && frame_tick) begin
            m_inv--;
            if (m_inv == 0) m_mode = 0;
        end
    endfunction

    task automatic step();
        bit exp_on;
        @(negedge clk);
        chk("rom_addr", 32'(rom_addr), 32'(m_addr(x, y)));
        p_in   = !reset && m_inside(x, y);
        p_von  = !reset && video_on;
        p_vis  = m_visible();
        p_addr = m_addr(x, y);
        @(posedge clk);
        model_update();
        #1;
        exp_on = p_in && p_von && p_vis && (rom_mem[p_addr] != KEY);
        chk("s_x", 32'(s_x), 32'(m_x));
        chk("s_y", 32'(s_y), 32'(m_y));
        chk("dir", 32'(dir), 32'(m_dir));
        chk("lives", 32'(lives), 32'(m_lives));
        chk("invuln", 32'(invuln), 32'(m_mode == 1));
        chk("game_over", 32'(game_over), 32'(m_mode == 2));
        chk("sprite_on", 32'(sprite_on), 32'(exp_on));
        chk("rgb_out", 32'(rgb_out), exp_on ? 32'(rom_mem[p_addr]) : 32'd0);
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            step();
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++)
            rom_mem[i] = ($urandom_range(0, 3) == 0) ? KEY : 12'($urandom);
        model_reset();
        step();
        step();
        chk("rst_lives", 32'(lives), 32'd3);
        chk("rst_pos", {6'd0, s_x, 6'd0, s_y}, {6'd0, 10'd320, 6'd0, 10'd432});
        chk("rst_flags", {29'd0, dir, invuln, game_over}, 32'd0);
        reset = 1'b0;

        btn_right = 1'b1; frames(10); btn_right = 1'b0;
        chk("tp_right_x", 32'(s_x), 32'd340);
        chk("tp_right_dir", 32'(dir), 32'd0);
        btn_left = 1'b1; frames(1);
        chk("tp_left_x", 32'(s_x), 32'd338);
        chk("tp_left_dir", 32'(dir), 32'd1);
        frames(199); btn_left = 1'b0;
        chk("tp_sat_x", 32'(s_x), 32'd0);
        btn_down = 1'b1; frames(20); btn_down = 1'b0;
        chk("tp_sat_y", 32'(s_y), 32'd448);
        btn_right = 1'b1; frames(5);
        btn_left = 1'b1; btn_up = 1'b1; btn_down = 1'b1; frames(3);
        btn_left = 1'b0; btn_right = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        chk("tp_both_x", 32'(s_x), 32'd10);
        chk("tp_both_dir", 32'(dir), 32'd0);

        x = 10'(m_x + 3); y = 10'(m_y + 3); video_on = 1'b1;
        rom_mem[51] = 12'h123; rom_mem[60] = 12'h123;
        collision = 1'b1; repeat (5) step(); collision = 1'b0;
        chk("tp_hit_lives", 32'(lives), 32'd2);
        chk("tp_hit_inv", 32'(invuln), 32'd1);
        frames(119);
        chk("tp_inv_119", 32'(invuln), 32'd1);
        frames(1);
        chk("tp_inv_end", 32'(invuln), 32'd0);
        collision = 1'b1; step(); collision = 1'b0;
        frames(120);
        collision = 1'b1; step(); collision = 1'b0;
        chk("tp_dead_lives", 32'(lives), 32'd0);
        chk("tp_dead_flag", 32'(game_over), 32'd1);
        btn_right = 1'b1; btn_down = 1'b1; frames(4); btn_right = 1'b0; btn_down = 1'b0;
        chk("tp_dead_frozen", 32'(s_x), 32'd10);
        reset = 1'b1; step(); reset = 1'b0;
        chk("tp_revive", 32'(lives), 32'd3);

        btn_left = 1'b1; frames(1); btn_left = 1'b0;
        x = 10'd318; y = 10'd432; video_on = 1'b1;
        rom_mem[15] = KEY;
        step();
        chk("tp_addr15", 32'(rom_addr), 32'd15);
        chk("tp_key_off", 32'(sprite_on), 32'd0);
        rom_mem[15] = 12'hF00;
        step();
        chk("tp_rgb", 32'(rgb_out), 32'hF00);
        chk("tp_rgb_on", 32'(sprite_on), 32'd1);

        collision = 1'b1; step(); collision = 1'b0;
        frames(5);
        chk("tp_hit2", 32'(invuln), 32'd1);
        reset = 1'b1; step(); reset = 1'b0;
        chk("tp_rst_inv", 32'(invuln), 32'd0);
        chk("tp_rst_lives", 32'(lives), 32'd3);
        chk("tp_rst_pos", {6'd0, s_x, 6'd0, s_y}, {6'd0, 10'd320, 6'd0, 10'd432});

        for (int i = 0; i < 1500; i++) begin
            btn_up     = 1'($urandom_range(0, 1));
            btn_down   = 1'($urandom_range(0, 1));
            btn_left   = 1'($urandom_range(0, 1));
            btn_right  = 1'($urandom_range(0, 1));
            frame_tick = ($urandom_range(0, 3) == 0);
            collision  = ($urandom_range(0, 40) == 0);
            reset      = ($urandom_range(0, 499) == 0);
            video_on   = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 7) == 0) begin
                x = 10'($urandom);
                y = 10'($urandom);
            end else begin
                x = 10'(clamp(m_x + $urandom_range(0, 32) - 8, 0, 1023));
                y = 10'(clamp(m_y + $urandom_range(0, 48) - 8, 0, 1023));
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
